// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pipe_pkg : opcode, flag and FSM state types for alu_pipe       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_PASSA = 4'd0,
    OP_PASSB = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_SHL   = 4'd7,
    OP_SHR   = 4'd8,
    OP_MUL   = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_mul_seq : iterative shift-add multiplier, one bit per edge     |
// | Used by alu_pipe when ALU_PIPE_MUL_EN is defined.   Rev 1.0        |
// +--------------------------------------------------------------------+
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= CNT_W'(WIDTH - 1);
    end else if (busy) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // High during the final step, so the owner can advance on the same edge.
  assign done    = busy && (cnt == '0);
  assign product = acc;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pipe : handshaked WIDTH-bit ALU with registered result/flags   |
// | Define ALU_PIPE_MUL_EN to add the iterative MUL op.  Rev 1.0       |
// +--------------------------------------------------------------------+
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             busy
);

  if (WIDTH < 4 || WIDTH > 32 || MUL_CYCLES != WIDTH) begin : g_cfg_check
    $error("alu_pipe: WIDTH must be 4..32 and MUL_CYCLES must equal WIDTH");
  end

  alu_state_t       state;
  alu_flags_t       flags;
  alu_flags_t       res_flags;
  alu_flags_t       nxt_flags;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] nxt_out;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             accept;
  logic             handoff;
  logic             load;

  assign in_ready = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;

  always_comb begin
    sum       = {1'b0, accum} + {1'b0, data};
    diff      = {1'b0, accum} - {1'b0, data};
    res       = accum;
    res_flags = '0;
    case (alu_op_t'(op))
      OP_PASSA: res = accum;
      OP_PASSB: res = data;
      OP_ADD: begin
        res                = sum[WIDTH-1:0];
        res_flags.carry    = sum[WIDTH];
        res_flags.overflow = (accum[WIDTH-1] == data[WIDTH-1]) &&
                             (res[WIDTH-1] != accum[WIDTH-1]);
      end
      OP_SUB: begin
        res                = diff[WIDTH-1:0];
        res_flags.carry    = diff[WIDTH];
        res_flags.overflow = (accum[WIDTH-1] != data[WIDTH-1]) &&
                             (res[WIDTH-1] != accum[WIDTH-1]);
      end
      OP_AND: res = accum & data;
      OP_OR:  res = accum | data;
      OP_XOR: res = accum ^ data;
      OP_SHL: begin
        res             = accum << 1;
        res_flags.carry = accum[WIDTH-1];
      end
      OP_SHR: begin
        res             = accum >> 1;
        res_flags.carry = accum[0];
      end
      // MUL is handled by the sequencer; illegal codes pass accum through.
      default: res = accum;
    endcase
    res_flags.zero     = (res == '0);
    res_flags.negative = res[WIDTH-1];
  end

`ifdef ALU_PIPE_MUL_EN
  alu_state_t         state_nxt;
  alu_flags_t         mul_flags;
  logic [2*WIDTH-1:0] product;
  logic               mul_done;
  logic               is_mul;

  assign is_mul = (op == OP_MUL);

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (accum),
    .b       (data),
    .busy    (busy),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mul_flags          = '0;
    mul_flags.carry    = |product[2*WIDTH-1:WIDTH];
    mul_flags.zero     = (product[WIDTH-1:0] == '0);
    mul_flags.negative = product[WIDTH-1];
  end

  always_comb begin
    nxt_out   = res;
    nxt_flags = res_flags;
    load      = accept && !is_mul;
    if (state == ST_DONE) begin
      nxt_out   = product[WIDTH-1:0];
      nxt_flags = mul_flags;
      load      = 1'b1;
    end
  end
`else
  assign state = ST_IDLE;
  assign busy  = 1'b0;

  always_comb begin
    nxt_out   = res;
    nxt_flags = res_flags;
    load      = accept;
  end
`endif

  // An accepted MUL also lands in the drop branch, clearing out_valid while it iterates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out       <= nxt_out;
      flags     <= nxt_flags;
      out_valid <= 1'b1;
    end else if (accept || handoff) begin
      out_valid <= 1'b0;
    end
  end

  assign zero     = flags.zero;
  assign carry    = flags.carry;
  assign negative = flags.negative;
  assign overflow = flags.overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_pipe : randomized self-checking bench for alu_pipe          |
// | Follows ALU_PIPE_MUL_EN the same way as the RTL.     Rev 1.0       |
// +--------------------------------------------------------------------+
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op = '0;
  logic [W-1:0] accum = '0;
  logic [W-1:0] data = '0;
  logic         in_ready, out_valid, zero, carry, negative, overflow, busy;
  logic [W-1:0] out;
  logic [11:0]  obs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .MUL_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .accum(accum), .data(data), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .carry(carry), .negative(negative),
    .overflow(overflow), .busy(busy)
  );

  assign obs = {overflow, negative, carry, zero, out};

  // Expected {V, N, C, Z, out[7:0]} from integer arithmetic on the opcode rules.
  function automatic logic [11:0] model(input int o, input int a, input int b);
    int r, c, v, sa, sb, s;
    r = a; c = 0; v = 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (o)
      1: r = b;
      2: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; s = sa + sb;
               v = (s > 127 || s < -128) ? 1 : 0; end
      3: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; s = sa - sb;
               v = (s > 127 || s < -128) ? 1 : 0; end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: begin r = (a * 2) % 256; c = a / 128; end
      8: begin r = a / 2; c = a % 2; end
`ifdef ALU_PIPE_MUL_EN
      9: begin r = (a * b) % 256; c = (a * b > 255) ? 1 : 0; end
`endif
      default: r = a;
    endcase
    return {v[0], (r >= 128), c[0], (r == 0), r[7:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int o, input int a, input int b);
    in_valid = 1'b1;
    op       = o[3:0];
    accum    = a[7:0];
    data     = b[7:0];
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    tests++; if (obs !== 12'h000) begin fails++; $display("FAIL reset_out_flags got %h want 000", obs); end
    step(); step();
    @(negedge clk) rst = 1'b0;
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_directed();
    int          vo[3]   = '{2, 2, 3};
    int          va[3]   = '{'h7F, 'hFF, 'h10};
    int          vb[3]   = '{'h01, 'h01, 'h20};
    logic [11:0] vexp[3] = '{12'hC80, 12'h300, 12'h6F0};
    for (int i = 0; i < 3; i++) begin
      drive(vo[i], va[i], vb[i]);
      step();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL directed_valid[%0d] got %0b want 1", i, out_valid); end
      tests++; if (obs !== vexp[i]) begin fails++; $display("FAIL directed_result[%0d] got %h want %h", i, obs, vexp[i]); end
      step();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL directed_drop got %0b want 0", out_valid); end
  endtask

  task automatic test_random();
    int o, a, b;
    for (int i = 0; i < 40; i++) begin
      o = int'($urandom_range(0, 15));
`ifdef ALU_PIPE_MUL_EN
      if (o == 9) o = 10;
`endif
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      drive(o, a, b);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL random_in_ready[%0d] got %0b want 1", i, in_ready); end
      step();
      tests++; if (out_valid !== 1'b1 || obs !== model(o, a, b)) begin
        fails++; $display("FAIL random_result[%0d] op=%0d a=%h b=%h got v=%0b %h want v=1 %h", i, o, a, b, out_valid, obs, model(o, a, b));
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int o, a, b;
    out_ready = 1'b0;
    drive(6, 'hAA, 'h0F);
    step();
    drive(2, 'h33, 'h44);
    for (int k = 0; k < 3; k++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %0b want 0", k, in_ready); end
      tests++; if (out_valid !== 1'b1 || obs !== model(6, 'hAA, 'h0F)) begin
        fails++; $display("FAIL bp_hold[%0d] got v=%0b %h want v=1 %h", k, out_valid, obs, model(6, 'hAA, 'h0F));
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
    step();
    tests++; if (out_valid !== 1'b1 || obs !== model(2, 'h33, 'h44)) begin
      fails++; $display("FAIL bp_pending_add got v=%0b %h want v=1 %h", out_valid, obs, model(2, 'h33, 'h44));
    end
    for (int k = 0; k < 4; k++) begin
      o = int'($urandom_range(0, 8));
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      drive(o, a, b);
      step();
      tests++; if (out_valid !== 1'b1 || obs !== model(o, a, b)) begin
        fails++; $display("FAIL stream[%0d] got v=%0b %h want v=1 %h", k, out_valid, obs, model(o, a, b));
      end
    end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_mul();
`ifdef ALU_PIPE_MUL_EN
    drive(9, 'h12, 'h10);
    step();
    drive(2, 'h01, 'h01);
    for (int k = 0; k < 8; k++) begin
      tests++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        fails++; $display("FAIL mul_iter[%0d] got busy=%0b valid=%0b ready=%0b want 1 0 0", k, busy, out_valid, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL mul_done_state got busy=%0b valid=%0b want 0 0", busy, out_valid);
    end
    step();
    tests++; if (out_valid !== 1'b1 || obs !== 12'h220) begin
      fails++; $display("FAIL mul_result got v=%0b %h want v=1 220", out_valid, obs);
    end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mul_ignored_add got valid=%0b want 0", out_valid); end
`else
    drive(9, 'h12, 'h10);
    step();
    tests++; if (out_valid !== 1'b1 || obs !== 12'h012) begin
      fails++; $display("FAIL mul_as_illegal got v=%0b %h want v=1 012", out_valid, obs);
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mul_off_busy got %0b want 0", busy); end
    drive(12, 'h12, 'h10);
    step();
    tests++; if (out_valid !== 1'b1 || obs !== model(12, 'h12, 'h10)) begin
      fails++; $display("FAIL illegal_op got v=%0b %h want v=1 %h", out_valid, obs, model(12, 'h12, 'h10));
    end
    in_valid = 1'b0;
    step();
`endif
  endtask

  task automatic test_reset_mid_op();
`ifdef ALU_PIPE_MUL_EN
    drive(9, 'hFF, 'hFF);
    step();
    in_valid = 1'b0;
    step(); step(); step();
`else
    out_ready = 1'b0;
    drive(2, 'h55, 'h11);
    step();
    in_valid = 1'b0;
`endif
    #2 rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL async_reset_ctrl got valid=%0b busy=%0b ready=%0b want 0 0 0", out_valid, busy, in_ready);
    end
    tests++; if (obs !== 12'h000) begin fails++; $display("FAIL async_reset_out got %h want 000", obs); end
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL aborted_no_result got %0b want 0", out_valid); end
    drive(2, 'h03, 'h04);
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || obs !== 12'h007) begin
      fails++; $display("FAIL post_reset_add got v=%0b %h want v=1 007", out_valid, obs);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mul();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the CPU's 8-bit accumulator ALU.
- Adds WIDTH generalisation, a registered result with valid/ready flow control, and a full flag set (zero, carry, negative, overflow).
- Adds an optional multi-cycle iterative multiplier.
- Sits between the decode/accumulator stage and writeback; downstream may stall it.

Parameters:
- WIDTH, 8: operand/result width in bits; legal range 4..32.
- MUL_CYCLES, WIDTH: multiplier iteration count; fixed equal to WIDTH, exposed for the bench only.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  4  alu_op_t opcode.
- accum  in  WIDTH  operand A.
- data  in  WIDTH  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  registered result.
- zero  out  1  result == 0.
- carry  out  1  carry/borrow/shift-out/mul-overflow.
- negative  out  1  result MSB.
- overflow  out  1  signed overflow (ADD/SUB only).
- busy  out  1  multiplier iterating.

Behaviour:
- Reset: asynchronous on rst=1; in effect immediately, not at the next edge. out=0, all flags 0, out_valid=0, busy=0, state IDLE. in_ready is 0 while rst=1.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at throughput 1.
- Single-cycle ops: result, flags and out_valid register on the accept edge, so latency is 1.
- out_valid holds, and out/flags are stable, until out_valid && out_ready. It then drops unless a new op is accepted on the same edge.
- Opcodes (alu_op_t):
  - PASSA=0: out=accum.
  - PASSB=1: out=data.
  - ADD=2: out=accum+data.
  - SUB=3: out=accum-data.
  - AND=4, OR=5, XOR=6: bitwise.
  - SHL=7, SHR=8: logical shift by 1.
  - MUL=9: multiply, see below.
  - 10..15 are illegal.
- Width rules: arithmetic is WIDTH+1 bits internally and out takes the low WIDTH bits.
- Carry:
  - ADD: carry-out.
  - SUB: borrow (1 when accum < data unsigned).
  - SHL: accum[WIDTH-1]; SHR: accum[0].
  - MUL: 1 if upper WIDTH product bits are nonzero.
  - All other ops: 0.
- Overflow: ADD/SUB signed two's-complement overflow; 0 for all other ops.
- zero and negative are computed from out for every op.
- Illegal opcode: out=accum, all flags 0 except zero/negative from out.
- FSM states: IDLE, MUL, DONE.
  - IDLE -> MUL on accepting MUL: load multiplicand/multiplier, clear the 2*WIDTH accumulator, busy=1, in_ready=0.
  - MUL: one shift-add step per edge for WIDTH edges; counter counts down from WIDTH-1 to 0; then -> DONE.
  - DONE: register out/flags, out_valid=1, busy=0, -> IDLE.
  - MUL result appears WIDTH+1 edges after the accept edge.
  - While busy, in_valid is ignored and out_ready has no effect; out_valid is 0 during MUL.
- Reset mid-MUL aborts the operation; no result is produced.
- Same-edge events: a result handoff (out_ready) and a new accept on one edge are legal; the new result replaces the old with no bubble.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- Defined: MUL opcode, FSM states MUL/DONE, busy and the multiplier sub-module are compiled in.
- Undefined: MUL is treated as an illegal opcode (1-cycle, out=accum). busy is tied 0, the FSM reduces to IDLE, and no multiplier logic is synthesised.

Decomposition:
- Shared package typedefs holds:
  - alu_op_t: 4-bit enum with the codes above.
  - alu_flags_t: packed struct {zero, carry, negative, overflow}.
  - alu_state_t enum.
- The existing CPU opcode_t remains separate.
- One sub-module: alu_mul_seq, the iterative shift-add multiplier. Ports: start, a, b, busy, done, product[2*WIDTH]. Instantiated under ALU_PIPE_MUL_EN.

Test Plan:
- WIDTH=8, ADD 0x7F+0x01 -> out=0x80 one edge after accept, N=1, V=1, C=0, Z=0.
- ADD 0xFF+0x01 -> out=0x00, Z=1, C=1, V=0; SUB 0x10-0x20 -> out=0xF0, C=1, N=1, V=0.
- Backpressure:
  - Stimulus: hold out_ready=0 after XOR 0xAA^0x0F.
  - Expected: out=0xA5 stable and in_ready=0 with a pending ADD held.
  - Release out_ready: ADD result appears next edge with no lost op; then stream 4 ops and check throughput of 1 per cycle.
- MUL 0x12*0x10 (macro on):
  - busy=1 for 8 edges, out_valid on the 9th edge after accept.
  - out=0x20, C=1; in_valid is ignored while busy.
- Assert rst asynchronously during MUL iteration 4 -> out_valid=0, busy=0, out=0 immediately. After release, ADD 0x03+0x04 -> out=0x07.
- Macro off, or op=0xC: MUL 0x12*0x10 -> out=0x12 after 1 edge, C=0, V=0, busy never asserts.
